// File: rtl/adc_dac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_dac_pkg
// Description : Shared constants and FSM state encoding for the ADC-to-DAC
//               sample sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_dac_pkg;

    // Default widths of the sample bus and the ADC configuration word
    localparam int c_DEF_DATA_W     = 10;
    localparam int c_DEF_CFG_W      = 16;

    // Shortest tick period that still fits the six-cycle sample schedule
    localparam int c_MIN_SAMPLE_DIV = 8;

    // Sequencer state encoding
    localparam int c_ST_W = 3;
    localparam logic [c_ST_W-1:0] c_ST_IDLE    = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_CFG_LO  = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_CFG_HI  = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_CAPTURE = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_SETUP_A = 3'd4;
    localparam logic [c_ST_W-1:0] c_ST_WRITE_A = 3'd5;
    localparam logic [c_ST_W-1:0] c_ST_SETUP_B = 3'd6;
    localparam logic [c_ST_W-1:0] c_ST_WRITE_B = 3'd7;

endpackage
`default_nettype wire

// File: rtl/adc_cfg_shifter.sv
`default_nettype none
// ============================================================================
// Module      : adc_cfg_shifter
// Description : Shifts a configuration word to the ADC MSB first, two clock
//               cycles per bit (sclk low, then sclk high with sdi held).
// Revision    : 1.0 - initial release
// ============================================================================
module adc_cfg_shifter
    import adc_dac_pkg::*;
#(
    parameter int CFG_W = c_DEF_CFG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CFG_W-1:0] cfg_word,
    output logic             sdi,
    output logic             sclk,
    output logic             busy,
    output logic             done
);

    localparam int c_CNT_W = (CFG_W > 1) ? $clog2(CFG_W) : 1;

    logic [CFG_W-1:0]   r_shreg;
    logic [c_CNT_W-1:0] r_bit;
    logic               r_phase;   // 0: sclk low half, 1: sclk high half
    logic               r_active;
    logic               w_last;

    assign w_last = (r_bit == c_CNT_W'(CFG_W - 1));

    // Latch the word on load, then walk bit halves until the last bit's high half
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shreg  <= '0;
            r_bit    <= '0;
            r_phase  <= 1'b0;
            r_active <= 1'b0;
        end else if (load) begin
            r_shreg  <= cfg_word;
            r_bit    <= '0;
            r_phase  <= 1'b0;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (!r_phase) begin
                r_phase <= 1'b1;
            end else begin
                r_phase <= 1'b0;
                r_shreg <= {r_shreg[CFG_W-2:0], 1'b0};
                r_bit   <= r_bit + 1'b1;
                if (w_last) begin
                    r_active <= 1'b0;
                end
            end
        end
    end

    // Serial pins idle low whenever no transfer is in flight
    assign sdi  = r_active & r_shreg[CFG_W-1];
    assign sclk = r_active & r_phase;
    assign busy = r_active;
    assign done = r_active & r_phase & w_last;

endmodule
`default_nettype wire

// File: rtl/adc_dac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_dac_sequencer
// Description : Deterministic ADC-to-DAC sample schedule: serial ADC
//               configuration, programmable-rate sampling and two-channel DAC
//               writes with setup and strobe cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_dac_sequencer
    import adc_dac_pkg::*;
#(
    parameter int DATA_W     = c_DEF_DATA_W,
    parameter int CFG_W      = c_DEF_CFG_W,
    parameter int SAMPLE_DIV = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              en_a,
    input  logic              en_b,
    input  logic              invert_b,
    input  logic              cfg_start,
    input  logic [CFG_W-1:0]  cfg_word,
    input  logic              overrun_clr,
    input  logic [DATA_W-1:0] adc_in,
    output logic              adc_oe,
    output logic              sdi,
    output logic              sclk,
    output logic [DATA_W-1:0] dac_out,
    output logic              dac_wr_a,
    output logic              dac_wr_b,
    output logic              sample_valid,
    output logic              cfg_busy,
    output logic              overrun
);

    // A divider below the schedule length would overrun every sample, so clamp it
    localparam int c_DIV   = (SAMPLE_DIV < c_MIN_SAMPLE_DIV) ? c_MIN_SAMPLE_DIV : SAMPLE_DIV;
    localparam int c_CNT_W = $clog2(c_DIV);

    logic [c_ST_W-1:0]  r_state;
    logic [c_ST_W-1:0]  w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_sample;
    logic [DATA_W-1:0]  r_dac;
    logic               r_overrun;
    logic               w_tick;
    logic               w_load;
    logic               w_drop;
    logic               w_cfg_busy;
    logic               w_cfg_done;

    assign w_tick = enable & (r_cnt == c_CNT_W'(c_DIV - 1));

    // Sample-rate divider; parked at zero while the scheduler is disabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!enable || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        adc_oe       = 1'b0;
        sample_valid = 1'b0;
        dac_wr_a     = 1'b0;
        dac_wr_b     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (cfg_start) begin
                    w_next = c_ST_CFG_LO;
                    w_load = 1'b1;
                end else if (w_tick) begin
                    w_next = c_ST_CAPTURE;
                end
            end
            c_ST_CFG_LO: begin
                adc_oe = 1'b1;
                w_next = c_ST_CFG_HI;
            end
            c_ST_CFG_HI: begin
                adc_oe = 1'b1;
                w_next = w_cfg_done ? c_ST_IDLE : c_ST_CFG_LO;
            end
            c_ST_CAPTURE: begin
                sample_valid = 1'b1;
                w_next       = c_ST_SETUP_A;
            end
            c_ST_SETUP_A: begin
                w_next = c_ST_WRITE_A;
            end
            c_ST_WRITE_A: begin
                dac_wr_a = en_a;
                w_next   = c_ST_SETUP_B;
            end
            c_ST_SETUP_B: begin
                w_next = c_ST_WRITE_B;
            end
            c_ST_WRITE_B: begin
                dac_wr_b = en_b;
                w_next   = c_ST_IDLE;
            end
            default: begin
                w_next = c_ST_IDLE;
            end
        endcase
    end

    // Sample capture and DAC bus: each channel's value is loaded one cycle
    // ahead of its strobe and held through it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sample <= '0;
            r_dac    <= '0;
        end else if (r_state == c_ST_CAPTURE) begin
            r_sample <= adc_in;
            r_dac    <= adc_in;
        end else if (r_state == c_ST_WRITE_A) begin
            r_dac    <= invert_b ? ~r_sample : r_sample;
        end
    end

    // A tick that cannot start a capture is lost; record it until cleared
    assign w_drop = w_tick & ((r_state != c_ST_IDLE) | cfg_start);

    // Sticky overrun flag, set has priority over clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    adc_cfg_shifter #(
        .CFG_W (CFG_W)
    ) u_cfg_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .cfg_word (cfg_word),
        .sdi      (sdi),
        .sclk     (sclk),
        .busy     (w_cfg_busy),
        .done     (w_cfg_done)
    );

    assign dac_out  = r_dac;
    assign overrun  = r_overrun;
    assign cfg_busy = w_cfg_busy;

endmodule
`default_nettype wire

// File: doc/adc_dac_sequencer.md
# adc_dac_sequencer

Sequences the 10-bit ADC-to-DAC sample path on the lab board. It serially configures the ADC, samples it at a programmable rate, and writes each sample into DAC channels A and B with explicit setup and strobe cycles. It sits between the board ADC/DAC pins and the top level, replacing the free-running passthrough wiring with a deterministic, single-clock schedule.

## Interface
- DATA_W, 10, ADC/DAC sample width
- CFG_W, 16, ADC configuration word width
- SAMPLE_DIV, 16, clk cycles per sample tick; legal values are ≥ 8
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  sample scheduler run enable
- en_a, en_b  in  1 each  per-channel DAC write enable
- invert_b  in  1  channel B receives (2^DATA_W − 1) − sample
- cfg_start  in  1  one-cycle request to shift cfg_word out to the ADC
- cfg_word  in  CFG_W  configuration word, sent MSB first
- overrun_clr  in  1  clears the overrun flag
- adc_in  in  DATA_W  parallel ADC data
- adc_oe  out  1  ADC output enable, active-low
- sdi  out  1  ADC serial config data
- sclk  out  1  ADC serial config clock
- dac_out  out  DATA_W  DAC data bus, shared by channels A and B
- dac_wr_a, dac_wr_b  out  1 each  DAC write strobes, active-high, one cycle wide
- sample_valid  out  1  one-cycle pulse when a sample is captured
- cfg_busy  out  1  high while configuration is in progress
- overrun  out  1  sticky flag: a sample tick was dropped

## Operation
- **Tick counter**
  - Counts 0..SAMPLE_DIV−1.
  - A tick occurs when the count is SAMPLE_DIV−1 and enable=1.
  - enable=0 holds the count at 0 and generates no ticks.
- **FSM states:** IDLE, CFG_LO, CFG_HI, CAPTURE, SETUP_A, WRITE_A, SETUP_B, WRITE_B.
- **Transitions from IDLE**
  - cfg_start → CFG_LO. This load takes priority over a tick in the same cycle.
  - Otherwise, a tick → CAPTURE.
- **Config path**
  - Each bit takes two cycles: CFG_LO drives sdi=bit with sclk=0, then CFG_HI holds sdi with sclk=1.
  - After CFG_W bits the FSM returns to IDLE, sdi returns to 0 and sclk to 0.
  - cfg_busy=1 and adc_oe=1 (ADC output disabled) in all CFG states.
  - cfg_word is latched when cfg_start is accepted.
  - cfg_start outside IDLE is ignored.
- **Sample path**
  - CAPTURE: adc_in is registered into the sample register and sample_valid pulses.
  - SETUP_A: dac_out = sample.
  - WRITE_A: dac_out is held and dac_wr_a = en_a.
  - SETUP_B: dac_out = invert_b ? ~sample : sample.
  - WRITE_B: dac_out is held and dac_wr_b = en_b.
  - WRITE_B → IDLE.
- **Disabled channels:** the channel's states are still traversed, so the schedule length is fixed; only the strobe is suppressed.
- **Overrun**
  - A tick that arrives in any state other than IDLE, or together with an accepted cfg_start, sets overrun and is dropped.
  - overrun_clr clears overrun. If a set and a clear occur in the same cycle, the set wins.
- **dac_out** holds its last value in IDLE and CFG states.

## Timing
- **Reset values** (asserted immediately on reset=0): every output is 0, including dac_out = 0, adc_oe = 0, and overrun = 0. The FSM goes to IDLE and the tick counter to 0.
- **Reset mid-sequence** aborts with no partial strobe; a reset mid-config leaves sclk=0.
- **Sample latency:** for a tick in cycle t:
  - sample_valid and CAPTURE in t+1;
  - dac_wr_a in t+3;
  - dac_wr_b in t+5;
  - back in IDLE at t+6.
- **Strobe setup:** data is stable on dac_out for one full cycle before and during each strobe.
- **Config duration:** 2·CFG_W cycles from the cycle after cfg_start. cfg_busy rises in the cycle after cfg_start and falls on return to IDLE.
- **Sample rate:** with enable held high, ticks are exactly SAMPLE_DIV cycles apart. Because SAMPLE_DIV ≥ 8, back-to-back samples never overrun.

## Structure
- **Shared package `adc_dac_pkg`:**
  - FSM state encoding;
  - default DATA_W and CFG_W;
  - the MIN_SAMPLE_DIV = 8 constant.
- **Sub-module `adc_cfg_shifter`:**
  - inputs: load, cfg_word;
  - outputs: sdi, sclk, busy, done;
  - contains the bit counter and shift register.
  - The top FSM instantiates it and waits for done.

## Test plan
- **Reset:** reset=0 mid-WRITE_A → all outputs 0 immediately; after release, the first tick occurs SAMPLE_DIV cycles later.
- **Sample path:** enable=1, adc_in=10'h2A5, en_a=en_b=1, invert_b=0 → dac_wr_a with dac_out=2A5 at t+3, dac_wr_b with 2A5 at t+5, repeating every 16 cycles.
- **Inversion and channel disable:** invert_b=1, adc_in=10'h0F0, en_a=0 → no dac_wr_a; dac_wr_b with dac_out=10'h30F.
- **Config shift:** cfg_start with cfg_word=16'hA53C in IDLE →
  - 32 cycles of sclk toggling, with sdi sampled on the sclk highs = A53C MSB first;
  - adc_oe=1 and cfg_busy=1 throughout, then both return to 0.
- **Config/tick collision:** cfg_start and a tick in the same cycle → config runs, the tick is dropped, overrun=1. overrun_clr → overrun=0.
- **Ignored request:** cfg_start during SETUP_B → ignored, cfg_busy stays 0, the sample sequence completes unchanged.
